// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: debug register access channel between the debug APB
// slave (master side) and the run-control sequencer (slave side).
//
// Signals:
//   req      - access strobe, one cycle per access
//   wr_rd    - 1 = write, 0 = read
//   addr     - debug register address
//   wdata    - write data
//   rdata    - registered read data
//   rd_ready - one-cycle pulse, rdata valid
interface core_run_ctrl_if #(
  parameter int DBG_ADDR_WIDTH = 5,
  parameter int DBG_DATA_WIDTH = 32
);

  logic                      req;
  logic                      wr_rd;
  logic [DBG_ADDR_WIDTH-1:0] addr;
  logic [DBG_DATA_WIDTH-1:0] wdata;
  logic [DBG_DATA_WIDTH-1:0] rdata;
  logic                      rd_ready;

  modport master (
    output req, wr_rd, addr, wdata,
    input  rdata, rd_ready
  );

  modport slave (
    input  req, wr_rd, addr, wdata,
    output rdata, rd_ready
  );

endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: debug run-control sequencer. Halts, resumes and
// single-steps the core by stalling fetch, waiting for the pipeline to
// drain and redirecting fetch to a debugger-supplied PC. Owns the debug
// register bank CTRL(0), STATUS(1), PC(2), STEP_CNT(3).
//
// Optional feature: define CORE_RUN_CTRL_BKPT_EN to add a single
// retire-address breakpoint register BKPT(4) and the sticky STATUS bit1.
//
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   dbg            - debug register channel (slave modport)
//   fetch_stall    - 1 = fetch must not issue
//   redirect_valid - one-cycle pulse, fetch restarts at redirect_addr
//   redirect_addr  - resume word address
//   pipe_empty     - no valid instruction in any pipeline stage
//   retire_valid   - instruction retired this cycle
//   retire_addr    - word address of the retiring instruction
//   halted         - core halted with the pipeline empty
module core_run_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DBG_ADDR_WIDTH = 5,
  parameter int DBG_DATA_WIDTH = 32,
  parameter bit HALT_ON_RST    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  core_run_ctrl_if.slave        dbg,
  output logic                  fetch_stall,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-3:0] redirect_addr,
  input  logic                  pipe_empty,
  input  logic                  retire_valid,
  input  logic [ADDR_WIDTH-3:0] retire_addr,
  output logic                  halted
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    HALTING    = 3'd1,
    HALTED     = 3'd2,
    RESUMING   = 3'd3,
    STEP_ISSUE = 3'd4,
    STEP_WAIT  = 3'd5
  } state_t;

  localparam logic [DBG_ADDR_WIDTH-1:0] REG_CTRL   = DBG_ADDR_WIDTH'(0);
  localparam logic [DBG_ADDR_WIDTH-1:0] REG_STATUS = DBG_ADDR_WIDTH'(1);
  localparam logic [DBG_ADDR_WIDTH-1:0] REG_PC     = DBG_ADDR_WIDTH'(2);
  localparam logic [DBG_ADDR_WIDTH-1:0] REG_STEP   = DBG_ADDR_WIDTH'(3);
`ifdef CORE_RUN_CTRL_BKPT_EN
  localparam logic [DBG_ADDR_WIDTH-1:0] REG_BKPT   = DBG_ADDR_WIDTH'(4);
`endif

  state_t                state;
  logic [ADDR_WIDTH-3:0] pc_q;
  logic [ADDR_WIDTH-3:0] resume_pc;
  logic                  pc_dirty;
  logic [31:0]           step_cnt;
  logic                  bkpt_hit;
  logic                  bkpt_trip;

  logic                      wr_en;
  logic                      rd_en;
  logic                      ctrl_wr;
  logic                      pc_wr;
  logic                      halt_cmd;
  logic                      step_cmd;
  logic                      resume_cmd;
  logic [DBG_DATA_WIDTH-1:0] rd_value;

  assign wr_en   = dbg.req & dbg.wr_rd;
  assign rd_en   = dbg.req & ~dbg.wr_rd;
  assign ctrl_wr = wr_en & (dbg.addr == REG_CTRL);
  assign pc_wr   = wr_en & (dbg.addr == REG_PC);

  // Command priority HALT > STEP > RESUME: a lower command is masked off
  // whenever a higher one is present in the same CTRL write, even if the
  // higher one turns out to have no effect in the current state.
  assign halt_cmd   = ctrl_wr & dbg.wdata[0];
  assign step_cmd   = ctrl_wr & ~dbg.wdata[0] & dbg.wdata[2];
  assign resume_cmd = ctrl_wr & ~dbg.wdata[0] & ~dbg.wdata[2] & dbg.wdata[1];

`ifdef CORE_RUN_CTRL_BKPT_EN
  logic                  bkpt_en;
  logic [ADDR_WIDTH-3:0] bkpt_addr;
  logic                  bkpt_wr;

  assign bkpt_wr   = wr_en & (dbg.addr == REG_BKPT);
  assign bkpt_trip = retire_valid & bkpt_en & (retire_addr == bkpt_addr);
`else
  assign bkpt_trip = 1'b0;
  assign bkpt_hit  = 1'b0;
`endif

  // Run-control FSM plus the state it owns. Outputs are registered, so each
  // transition also sets the fetch_stall/halted/redirect values that belong
  // to the state being entered. The redirect pulse is launched on entry to
  // RESUMING/STEP_ISSUE so it lines up with that one-cycle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= HALT_ON_RST ? HALTED : RUN;
      fetch_stall    <= HALT_ON_RST;
      halted         <= HALT_ON_RST;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      pc_q           <= '0;
      resume_pc      <= '0;
      pc_dirty       <= 1'b0;
      step_cnt       <= '0;
`ifdef CORE_RUN_CTRL_BKPT_EN
      bkpt_en        <= 1'b0;
      bkpt_addr      <= '0;
      bkpt_hit       <= 1'b0;
`endif
    end else begin
      redirect_valid <= 1'b0;

      if (retire_valid) begin
        pc_q <= retire_addr;
      end

      if (retire_valid && (state == STEP_ISSUE || state == STEP_WAIT)) begin
        step_cnt <= step_cnt + 32'd1;
      end

      if (pc_wr && state == HALTED) begin
        resume_pc <= dbg.wdata[ADDR_WIDTH-1:2];
        pc_dirty  <= 1'b1;
      end

`ifdef CORE_RUN_CTRL_BKPT_EN
      if (bkpt_wr) begin
        bkpt_en   <= dbg.wdata[0];
        bkpt_addr <= dbg.wdata[ADDR_WIDTH-1:2];
      end
`endif

      case (state)
        RUN: begin
          if (halt_cmd || bkpt_trip) begin
            state       <= HALTING;
            fetch_stall <= 1'b1;
`ifdef CORE_RUN_CTRL_BKPT_EN
            if (bkpt_trip) begin
              bkpt_hit <= 1'b1;
            end
`endif
          end
        end
        HALTING: begin
          if (pipe_empty) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (step_cmd || resume_cmd) begin
            state       <= step_cmd ? STEP_ISSUE : RESUMING;
            fetch_stall <= ~step_cmd;
            halted      <= 1'b0;
            if (pc_dirty) begin
              redirect_valid <= 1'b1;
              redirect_addr  <= resume_pc;
              pc_dirty       <= 1'b0;
            end
`ifdef CORE_RUN_CTRL_BKPT_EN
            if (resume_cmd) begin
              bkpt_hit <= 1'b0;
            end
`endif
          end
        end
        RESUMING: begin
          state       <= RUN;
          fetch_stall <= 1'b0;
        end
        STEP_ISSUE: begin
          state       <= STEP_WAIT;
          fetch_stall <= 1'b1;
        end
        STEP_WAIT: begin
          if (retire_valid) begin
            state <= HALTING;
          end
        end
        default: begin
          state       <= RUN;
          fetch_stall <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

  // Read mux works on pre-edge state, so a STATUS read that coincides with
  // a transition reports the state being left.
  always_comb begin
    rd_value = '0;
    case (dbg.addr)
      REG_STATUS: rd_value = DBG_DATA_WIDTH'({state, bkpt_hit, halted});
      REG_PC:     rd_value = DBG_DATA_WIDTH'({pc_q, 2'b00});
      REG_STEP:   rd_value = DBG_DATA_WIDTH'(step_cnt);
`ifdef CORE_RUN_CTRL_BKPT_EN
      REG_BKPT:   rd_value = DBG_DATA_WIDTH'({bkpt_addr, 1'b0, bkpt_en});
`endif
      default:    rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg.rdata    <= '0;
      dbg.rd_ready <= 1'b0;
    end else begin
      dbg.rd_ready <= rd_en;
      if (rd_en) begin
        dbg.rdata <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed testbench for core_run_ctrl. Register reads
// push their expected value into a scoreboard queue; a monitor pops and
// compares whenever the DUT pulses rd_ready. Expected redirect pulses are
// handled the same way. Breakpoint checks are compiled in when
// CORE_RUN_CTRL_BKPT_EN is defined.
module tb_core_run_ctrl;

  localparam int AW  = 32;
  localparam int DAW = 5;
  localparam int DDW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_stall;
  logic          redirect_valid;
  logic [AW-3:0] redirect_addr;
  logic          pipe_empty;
  logic          retire_valid;
  logic [AW-3:0] retire_addr;
  logic          halted;

  int checks   = 0;
  int failures = 0;

  logic [31:0]   rd_q[$];
  string         rd_name_q[$];
  logic [AW-3:0] rdr_q[$];

  always #5 clk = ~clk;

  core_run_ctrl_if #(.DBG_ADDR_WIDTH(DAW), .DBG_DATA_WIDTH(DDW)) dbg_bus ();

  core_run_ctrl #(
    .ADDR_WIDTH    (AW),
    .DBG_ADDR_WIDTH(DAW),
    .DBG_DATA_WIDTH(DDW),
    .HALT_ON_RST   (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dbg           (dbg_bus),
    .fetch_stall   (fetch_stall),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .pipe_empty    (pipe_empty),
    .retire_valid  (retire_valid),
    .retire_addr   (retire_addr),
    .halted        (halted)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Drives one debug access for one cycle; called at a falling edge.
  task automatic applyStimulus(input logic wr, input logic [DAW-1:0] addr,
                               input logic [31:0] data, input logic [31:0] exp_rd,
                               input string name);
    dbg_bus.req   = 1'b1;
    dbg_bus.wr_rd = wr;
    dbg_bus.addr  = addr;
    dbg_bus.wdata = wr ? data : 32'h0;
    if (!wr) begin
      rd_q.push_back(exp_rd);
      rd_name_q.push_back(name);
    end
    @(negedge clk);
    dbg_bus.req   = 1'b0;
    dbg_bus.wr_rd = 1'b0;
  endtask

  task automatic dbgWrite(input logic [DAW-1:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, 32'h0, "write");
  endtask

  task automatic dbgRead(input logic [DAW-1:0] addr, input logic [31:0] exp_rd,
                         input string name);
    applyStimulus(1'b0, addr, 32'h0, exp_rd, name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: read data and redirect pulses.
  always @(negedge clk) begin
    if (dbg_bus.rd_ready) begin
      if (rd_q.size() == 0) begin
        checkOutput("unexpected_rd_ready", 32'd1, 32'd0);
      end else begin
        checkOutput(rd_name_q.pop_front(), dbg_bus.rdata, rd_q.pop_front());
      end
    end
    if (redirect_valid) begin
      if (rdr_q.size() == 0) begin
        checkOutput("unexpected_redirect", 32'(redirect_addr), 32'hFFFF_FFFF);
      end else begin
        checkOutput("redirect_addr", 32'(redirect_addr), 32'(rdr_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    dbg_bus.req   = 1'b0;
    dbg_bus.wr_rd = 1'b0;
    dbg_bus.addr  = '0;
    dbg_bus.wdata = '0;
    pipe_empty    = 1'b0;
    retire_valid  = 1'b0;
    retire_addr   = '0;

    // Reset state
    tick(2);
    checkOutput("rst_fetch_stall", 32'(fetch_stall), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("rst_rd_ready", 32'(dbg_bus.rd_ready), 32'd0);
    rst = 1'b0;
    tick(1);
    dbgRead(5'd1, 32'h0, "status_after_rst");
    dbgRead(5'd2, 32'h0, "pc_after_rst");
    dbgRead(5'd3, 32'h0, "stepcnt_after_rst");
    dbgRead(5'd0, 32'h0, "ctrl_reads_zero");
    dbgRead(5'd7, 32'h0, "unmapped_read");

    // Halt with the pipeline still busy for five cycles
    $display("[TB] halt sequence");
    dbgWrite(5'd0, 32'h1);
    checkOutput("halt_fetch_stall", 32'(fetch_stall), 32'd1);
    checkOutput("halting_not_halted", 32'(halted), 32'd0);
    tick(3);
    dbgRead(5'd1, 32'h4, "status_halting");
    checkOutput("halting_still_busy", 32'(halted), 32'd0);
    pipe_empty = 1'b1;
    tick(1);
    checkOutput("halted_rise", 32'(halted), 32'd1);
    dbgRead(5'd1, 32'h9, "status_halted");

    // Resume with a new PC, then resume again without one
    $display("[TB] resume sequence");
    dbgWrite(5'd2, 32'h0000_1040);
    rdr_q.push_back(30'h410);
    dbgWrite(5'd0, 32'h2);
    checkOutput("resuming_stall", 32'(fetch_stall), 32'd1);
    checkOutput("resuming_not_halted", 32'(halted), 32'd0);
    tick(1);
    checkOutput("resumed_stall", 32'(fetch_stall), 32'd0);
    dbgWrite(5'd0, 32'h1);
    tick(1);
    checkOutput("rehalted", 32'(halted), 32'd1);
    dbgWrite(5'd0, 32'h2);
    dbgRead(5'd1, 32'hC, "status_pre_transition");
    checkOutput("resume2_stall", 32'(fetch_stall), 32'd0);

    // Single step
    $display("[TB] step sequence");
    dbgWrite(5'd0, 32'h1);
    tick(1);
    checkOutput("halted_before_step", 32'(halted), 32'd1);
    dbgWrite(5'd0, 32'h4);
    checkOutput("step_issue_stall", 32'(fetch_stall), 32'd0);
    tick(1);
    checkOutput("step_wait_stall", 32'(fetch_stall), 32'd1);
    tick(1);
    retire_valid = 1'b1;
    retire_addr  = 30'h410;
    tick(1);
    retire_valid = 1'b0;
    checkOutput("step_halting_stall", 32'(fetch_stall), 32'd1);
    checkOutput("step_halting_halted", 32'(halted), 32'd0);
    tick(1);
    checkOutput("step_done_halted", 32'(halted), 32'd1);
    dbgRead(5'd3, 32'h1, "stepcnt_one");
    dbgRead(5'd2, 32'h0000_1040, "pc_after_step");
    dbgRead(5'd1, 32'h9, "status_after_step");

    // Commands while running, then HALT priority with a same-cycle retire
    $display("[TB] command priority");
    dbgWrite(5'd0, 32'h2);
    tick(2);
    checkOutput("run_again_stall", 32'(fetch_stall), 32'd0);
    dbgWrite(5'd0, 32'h2);
    dbgRead(5'd1, 32'h0, "resume_in_run_ignored");
    dbgWrite(5'd0, 32'h4);
    dbgRead(5'd1, 32'h0, "step_in_run_ignored");
    checkOutput("run_unaffected_stall", 32'(fetch_stall), 32'd0);
    pipe_empty   = 1'b0;
    retire_valid = 1'b1;
    retire_addr  = 30'h123;
    dbgWrite(5'd0, 32'h7);
    retire_valid = 1'b0;
    checkOutput("ctrl7_stall", 32'(fetch_stall), 32'd1);
    dbgRead(5'd1, 32'h4, "ctrl7_halting");
    pipe_empty = 1'b1;
    tick(1);
    checkOutput("ctrl7_halted", 32'(halted), 32'd1);
    dbgRead(5'd2, 32'h0000_048C, "pc_retire_with_halt");
    dbgRead(5'd3, 32'h1, "stepcnt_not_run_retire");

    // Asynchronous reset during STEP_WAIT
    $display("[TB] async reset");
    dbgWrite(5'd2, 32'h0000_2000);
    rdr_q.push_back(30'h800);
    dbgWrite(5'd0, 32'h4);
    tick(1);
    checkOutput("pre_rst_step_wait", 32'(fetch_stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_fetch_stall", 32'(fetch_stall), 32'd0);
    checkOutput("arst_halted", 32'(halted), 32'd0);
    checkOutput("arst_redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("arst_redirect_addr", 32'(redirect_addr), 32'd0);
    checkOutput("arst_rd_ready", 32'(dbg_bus.rd_ready), 32'd0);
    checkOutput("arst_rdata", dbg_bus.rdata, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    dbgRead(5'd1, 32'h0, "status_after_arst");
    dbgRead(5'd3, 32'h0, "stepcnt_after_arst");
    dbgWrite(5'd0, 32'h1);
    tick(1);
    checkOutput("halt_after_arst", 32'(halted), 32'd1);
    dbgWrite(5'd0, 32'h2);
    tick(2);
    checkOutput("resume_no_dirty_stall", 32'(fetch_stall), 32'd0);

`ifdef CORE_RUN_CTRL_BKPT_EN
    $display("[TB] breakpoint");
    dbgWrite(5'd4, 32'h0000_2001);
    dbgRead(5'd4, 32'h0000_2001, "bkpt_readback");
    retire_valid = 1'b1;
    retire_addr  = 30'h801;
    tick(1);
    retire_valid = 1'b0;
    checkOutput("bkpt_no_match", 32'(fetch_stall), 32'd0);
    retire_valid = 1'b1;
    retire_addr  = 30'h800;
    tick(1);
    retire_valid = 1'b0;
    checkOutput("bkpt_halting", 32'(fetch_stall), 32'd1);
    tick(1);
    checkOutput("bkpt_halted", 32'(halted), 32'd1);
    dbgRead(5'd1, 32'hB, "status_bkpt_hit");
    dbgWrite(5'd0, 32'h2);
    dbgRead(5'd1, 32'hC, "status_bkpt_cleared");
    dbgRead(5'd1, 32'h0, "status_run_after_bkpt");
`else
    dbgWrite(5'd4, 32'h0000_2001);
    dbgRead(5'd4, 32'h0, "bkpt_unmapped");
    retire_valid = 1'b1;
    retire_addr  = 30'h800;
    tick(1);
    retire_valid = 1'b0;
    tick(1);
    checkOutput("no_bkpt_stall", 32'(fetch_stall), 32'd0);
`endif

    tick(3);
    checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    checkOutput("redirect_queue_drained", 32'(rdr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
